// File: rtl/cla_bist_checker.sv
// Closed-loop BIST engine for a 4-bit carry-lookahead adder: it sweeps every operand vector, checks {cout,s}, counts mismatches and reports pass/fail.
// Optional feature: define CLA_BIST_CIN_SWEEP_EN to include cin in the sweep as the index MSB (512 vectors instead of 256).
module cla_bist_checker #(
  parameter int ERR_CNT_W    = 10,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [8:0]           first_fail_vec,
  output logic [3:0]           a,
  output logic [3:0]           b,
  output logic                 cin,
  input  logic [3:0]           s,
  input  logic                 cout
);

`ifdef CLA_BIST_CIN_SWEEP_EN
  localparam logic [8:0] LAST_VEC = 9'd511;
`else
  localparam logic [8:0] LAST_VEC = 9'd255;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [8:0]           r_vec;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [8:0]           r_first_fail;
  logic [4:0]           w_exp;
  logic                 w_run;
  logic                 w_mismatch;
  logic                 w_end;
  logic                 w_start_ok;

  // The operand outputs are the vector register itself, so the response seen
  // at each edge belongs to the vector currently held in r_vec.
  assign w_run      = (r_state == RUN);
  assign w_exp      = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign w_mismatch = w_run && ({cout, s} != w_exp);
  assign w_end      = (r_vec == LAST_VEC) || (STOP_ON_FAIL && w_mismatch);
  assign w_start_ok = start && !w_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_end) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A zero error count marks the first mismatch, and saturation keeps it from
  // ever returning to zero within a sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vec        <= '0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
    end else if (w_start_ok) begin
      r_vec        <= '0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
    end else if (w_run) begin
      if (w_mismatch) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        if (r_err_cnt == '0) r_first_fail <= r_vec;
      end
      r_vec <= w_end ? 9'd0 : r_vec + 9'd1;
    end
  end

  assign busy           = w_run;
  assign done           = (r_state == DONE);
  assign pass           = done && (r_err_cnt == '0);
  assign err_cnt        = r_err_cnt;
  assign first_fail_vec = r_first_fail;
  assign a              = r_vec[3:0];
  assign b              = r_vec[7:4];
  assign cin            = r_vec[8];

endmodule

// File: doc/cla_bist_checker.md
# cla_bist_checker

Built-in self-test engine for the 4-bit carry-lookahead adder (`cla_4bit`).
- Drives an exhaustive operand sweep into the adder under test and checks each `s`/`cout` response against an internal reference sum.
- Counts mismatches, records the first failing vector and reports pass/fail through a start/busy/done handshake.
- Sits beside `cla_4bit` as its response end: it replaces open-loop random stimulus with closed-loop checking.

## Interface
- `ERR_CNT_W`, 10: width of the mismatch counter. The counter saturates at all-ones.
- `STOP_ON_FAIL`, 0: when 1, the sweep ends at the first mismatch.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a sweep.
- `busy`  out  1  high while the sweep runs.
- `done`  out  1  high from sweep completion until the next accepted `start` or reset.
- `pass`  out  1  `done && err_cnt == 0`.
- `err_cnt`  out  `ERR_CNT_W`  number of mismatching vectors.
- `first_fail_vec`  out  9  index of the first mismatching vector, `{cin,b[3:0],a[3:0]}`.
- `a`  out  4  operand A to the adder. Bit i maps to `cla_4bit` port `a<i>`.
- `b`  out  4  operand B to the adder. Bit i maps to `b<i>`.
- `cin`  out  1  carry-in to the adder.
- `s`  in  4  sum from the adder. Bit i maps to `s<i>`.
- `cout`  in  1  carry-out from the adder.

## Operation
- States: IDLE, RUN, DONE.
- Reset value of every output is 0, and the state is IDLE.
- IDLE or DONE, with `start`=1:
  - next state is RUN;
  - `err_cnt`, `first_fail_vec` and the vector index `vec` clear to 0;
  - `busy`=1 and `done`=0.
- `start` in RUN is ignored.
- RUN: `{cin,b,a}` are registered outputs equal to `vec`.
- The adder is combinational, so its response is sampled at the next rising edge.
- On each RUN edge:
  - compute `exp = a + b + cin` as 5 bits;
  - a mismatch is `{cout,s} != exp`;
  - on a mismatch, increment `err_cnt`, saturating at `2^ERR_CNT_W-1`;
  - on the first mismatch only, latch `vec` into `first_fail_vec`;
  - then advance `vec` by 1.
- The sweep ends after the vector with index N-1 is compared. On that edge:
  - state moves to DONE;
  - `busy`=0 and `done`=1;
  - `a`, `b` and `cin` return to 0.
- If `STOP_ON_FAIL`=1, the first mismatch also ends the sweep on the same edge that compares it.
- DONE holds `err_cnt`, `first_fail_vec` and `pass` stable.
- Reset asserted mid-RUN returns all state and outputs to their reset values immediately. No partial results are kept.

## Timing
- `start` is sampled at edge E0. Vector 0 is driven after E0.
- Vector k-1 is compared at edge Ek, and vector k is driven after Ek.
- `done` rises after edge EN, exactly N cycles after the `start` edge. `busy` is high for N cycles.
- Throughput is one vector per clock. There is no drain cycle.
- `pass` and `done` change on the same edge.
- `start` in DONE restarts the sweep with the same timing as from IDLE.

## Configuration
- Macro: `CLA_BIST_CIN_SWEEP_EN`.
- Defined: `cin` is swept as the index MSB, giving N = 512 vectors. `first_fail_vec[8]` reflects `cin`.
- Undefined: `cin` is held at 0, giving N = 256 vectors. `vec[8]` and `first_fail_vec[8]` are always 0.

## Test plan
- Correct adder model, macro undefined, `start` pulse:
  - `busy` is high 256 cycles;
  - `done`=1 and `pass`=1;
  - `err_cnt`=0.
- `s[2]` stuck-at-0, macro undefined:
  - `err_cnt`=128 and `pass`=0;
  - `first_fail_vec`=4 (a=4, b=0).
  - With the macro defined: `err_cnt`=256 and N=512.
- `cout` stuck-at-1, macro undefined:
  - `err_cnt`=136 (vectors with a+b<16);
  - `first_fail_vec`=0.
- `cout` stuck-at-1 with `STOP_ON_FAIL`=1:
  - `done` rises 1 cycle after `start`;
  - `err_cnt`=1 and `first_fail_vec`=0.
- `cout` stuck-at-1 with `ERR_CNT_W`=4: `err_cnt` saturates at 15.
- Reset and `start` handling:
  - `rst` asserted 100 cycles into RUN forces every output to 0 immediately;
  - after release, `start` runs a full 256-cycle passing sweep;
  - a second `start` during RUN changes nothing.
